// File: rtl/mc_control_unit.sv
// Multicycle control FSM for the SPU core: sequences fetch through writeback,
// drives the datapath enables and ALUctr, and raises overflow/illegal traps.
module mc_control_unit #(
   parameter int STATE_W = 4
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [5:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               Zero,
   input  logic               Overfl,
   input  logic               MemAck,
   output logic               MemReq,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IorD,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic [1:0]         PCSource,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic               ExtOp,
   output logic [3:0]         ALUctr,
   output logic               RegWrite,
   output logic               RegDst,
   output logic               MemtoReg,
   output logic               Trap,
   output logic [1:0]         TrapCause,
   output logic [STATE_W-1:0] State
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_EXEC_I = 4'd3,
      S_WB_R   = 4'd4,
      S_WB_I   = 4'd5,
      S_ADDR   = 4'd6,
      S_MEM_RD = 4'd7,
      S_MEM_WR = 4'd8,
      S_WB_MEM = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t     state;
   state_t     nxt;
   logic [1:0] cause;
   logic [1:0] nxt_cause;
   logic       funct_ok;
   logic       is_imm;
   logic [3:0] imm_ctr;

   // Legal R-type: the 1000xx/1001xx arithmetic-logic block plus slt/sltu.
   assign funct_ok = (Funct[5:3] == 3'b100) ||
                     (Funct == 6'b101010) ||
                     (Funct == 6'b101011);
   assign is_imm   = (Op[5:3] == 3'b001) && (Op[2:0] != 3'b111);

   always_comb begin
      imm_ctr = 4'b0001;
      case (Op[2:0])
         3'b000:  imm_ctr = 4'b0000;
         3'b001:  imm_ctr = 4'b0001;
         3'b010:  imm_ctr = 4'b1010;
         3'b011:  imm_ctr = 4'b1011;
         3'b100:  imm_ctr = 4'b0100;
         3'b101:  imm_ctr = 4'b0101;
         3'b110:  imm_ctr = 4'b0110;
         default: imm_ctr = 4'b0001;
      endcase
   end

   always_comb begin
      MemReq    = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IorD      = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSource  = 2'b00;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ExtOp     = 1'b0;
      ALUctr    = 4'b0000;
      RegWrite  = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      Trap      = 1'b0;
      nxt       = state;
      nxt_cause = cause;
      // Reset forces every output low, including an in-flight MemReq.
      if (!Reset) begin
         case (state)
            S_FETCH: begin
               MemReq  = 1'b1;
               MemRead = 1'b1;
               if (MemAck) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  ALUSrcB = 2'b01;
                  ALUctr  = 4'b0001;
                  nxt     = S_DECODE;
               end
            end
            S_DECODE: begin
               ALUSrcB = 2'b11;
               ExtOp   = 1'b1;
               ALUctr  = 4'b0001;
               if (Op == OP_RTYPE && funct_ok) begin
                  nxt = S_EXEC_R;
               end else if (Op == OP_LW || Op == OP_SW) begin
                  nxt = S_ADDR;
               end else if (Op == OP_BEQ || Op == OP_BNE) begin
                  nxt = S_BRANCH;
               end else if (Op == OP_J) begin
                  nxt = S_JUMP;
               end else if (is_imm) begin
                  nxt = S_EXEC_I;
               end else begin
                  nxt       = S_TRAP;
                  nxt_cause = 2'b10;
               end
            end
            S_EXEC_R: begin
               ALUSrcA = 1'b1;
               ALUctr  = Funct[3:0];
               if (Overfl && (Funct[3:0] == 4'b0000 ||
                              Funct[3:0] == 4'b0010)) begin
                  nxt       = S_TRAP;
                  nxt_cause = 2'b01;
               end else begin
                  nxt = S_WB_R;
               end
            end
            S_EXEC_I: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               ExtOp   = ~Op[2];
               ALUctr  = imm_ctr;
               if (Overfl && Op[2:0] == 3'b000) begin
                  nxt       = S_TRAP;
                  nxt_cause = 2'b01;
               end else begin
                  nxt = S_WB_I;
               end
            end
            S_WB_R: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
               nxt      = S_FETCH;
            end
            S_WB_I: begin
               RegWrite = 1'b1;
               nxt      = S_FETCH;
            end
            S_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               ExtOp   = 1'b1;
               ALUctr  = 4'b0001;
               nxt     = (Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
               MemReq  = 1'b1;
               MemRead = 1'b1;
               IorD    = 1'b1;
               if (MemAck) nxt = S_WB_MEM;
            end
            S_MEM_WR: begin
               MemReq   = 1'b1;
               MemWrite = 1'b1;
               IorD     = 1'b1;
               if (MemAck) nxt = S_FETCH;
            end
            S_WB_MEM: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
               nxt      = S_FETCH;
            end
            S_BRANCH: begin
               ALUSrcA  = 1'b1;
               ALUctr   = 4'b0011;
               PCSource = 2'b01;
               PCWrite  = (Op == OP_BEQ) ? Zero : ~Zero;
               nxt      = S_FETCH;
            end
            S_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
               nxt      = S_FETCH;
            end
            S_TRAP: begin
               Trap     = 1'b1;
               PCWrite  = 1'b1;
               PCSource = 2'b11;
               nxt      = S_FETCH;
            end
            default: nxt = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= S_FETCH;
         cause <= 2'b00;
      end else begin
         state <= nxt;
         cause <= nxt_cause;
      end
   end

   assign TrapCause = Reset ? 2'b00 : cause;
   assign State     = Reset ? '0 : STATE_W'(state);

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: instruction-level model expands each random
// instruction into its per-cycle control vector and compares every cycle.
module tb_mc_control_unit;

   localparam int SW = 4;

   logic          Clk = 1'b0;
   logic          Reset;
   logic [5:0]    Op;
   logic [5:0]    Funct;
   logic          Zero;
   logic          Overfl;
   logic          MemAck;
   logic          MemReq;
   logic          MemRead;
   logic          MemWrite;
   logic          IorD;
   logic          IRWrite;
   logic          PCWrite;
   logic [1:0]    PCSource;
   logic          ALUSrcA;
   logic [1:0]    ALUSrcB;
   logic          ExtOp;
   logic [3:0]    ALUctr;
   logic          RegWrite;
   logic          RegDst;
   logic          MemtoReg;
   logic          Trap;
   logic [1:0]    TrapCause;
   logic [SW-1:0] State;

   mc_control_unit #(.STATE_W(SW)) dut (
      .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct),
      .Zero(Zero), .Overfl(Overfl), .MemAck(MemAck),
      .MemReq(MemReq), .MemRead(MemRead), .MemWrite(MemWrite),
      .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ExtOp(ExtOp), .ALUctr(ALUctr), .RegWrite(RegWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .Trap(Trap),
      .TrapCause(TrapCause), .State(State)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       req, rd, wr, iord, irw, pcw;
      logic [1:0] pcs;
      logic       sa;
      logic [1:0] sb;
      logic       ext;
      logic [3:0] ctr;
      logic       rw, rdst, m2r, trap;
      logic [1:0] cause;
   } out_t;

   out_t       act;
   out_t       exp_o;
   logic       chk = 1'b0;
   int         total = 0;
   int         bad = 0;
   int         trap_seen = 0;
   int         rw_seen = 0;
   int         irw_seen = 0;
   logic [1:0] cause_m = 2'b00;

   assign act = {MemReq, MemRead, MemWrite, IorD, IRWrite, PCWrite,
                 PCSource, ALUSrcA, ALUSrcB, ExtOp, ALUctr,
                 RegWrite, RegDst, MemtoReg, Trap, TrapCause};

   always @(negedge Clk) begin
      if (chk) begin
         total++;
         if (act !== exp_o) begin
            bad++;
            $display("FAIL outs t=%0t op=%b fn=%b got=%h want=%h",
                     $time, Op, Funct, act, exp_o);
         end
         if (Reset) begin
            total++;
            if (State !== '0) begin
               bad++;
               $display("FAIL state_in_reset got=%0d want=0", State);
            end
         end
         if (Trap) trap_seen++;
         if (RegWrite) rw_seen++;
         if (IRWrite) irw_seen++;
      end
   end

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(1));
   endfunction

   task automatic cyc(input logic ack, input logic z, input logic ov,
                      input out_t e);
      MemAck  = ack;
      Zero    = z;
      Overfl  = ov;
      e.cause = cause_m;
      exp_o   = e;
      chk     = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   task automatic reset_cyc();
      Reset   = 1'b1;
      MemAck  = rb();
      Zero    = rb();
      Overfl  = rb();
      exp_o   = '0;
      chk     = 1'b1;
      @(posedge Clk);
      #1;
      Reset   = 1'b0;
      cause_m = 2'b00;
   endtask

   function automatic out_t fetch_v(input logic ack);
      out_t e = '0;
      e.req = 1'b1;
      e.rd  = 1'b1;
      if (ack) begin
         e.irw = 1'b1;
         e.pcw = 1'b1;
         e.sb  = 2'b01;
         e.ctr = 4'b0001;
      end
      return e;
   endfunction

   function automatic bit r_legal(input logic [5:0] f);
      return f inside {6'b100000, 6'b100001, 6'b100010, 6'b100011,
                       6'b100100, 6'b100101, 6'b100110, 6'b100111,
                       6'b101010, 6'b101011};
   endfunction

   task automatic do_trap(input logic [1:0] c, inout int n);
      out_t e = '0;
      cause_m = c;
      e.trap  = 1'b1;
      e.pcw   = 1'b1;
      e.pcs   = 2'b11;
      cyc(rb(), rb(), rb(), e);
      n++;
   endtask

   task automatic do_wb(input logic rdst, input logic m2r, inout int n);
      out_t e = '0;
      e.rw   = 1'b1;
      e.rdst = rdst;
      e.m2r  = m2r;
      cyc(rb(), rb(), rb(), e);
      n++;
   endtask

   // Runs one instruction from FETCH back to FETCH; n counts its cycles.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input logic ov, input logic z,
                            input int fw, input int mw, input bit abort,
                            output int n);
      out_t       e;
      logic [3:0] c;
      logic       ex;
      bit         chk_ov;
      n     = 0;
      Op    = op;
      Funct = fn;
      for (int i = 0; i < fw; i++) begin
         cyc(1'b0, rb(), rb(), fetch_v(1'b0));
         n++;
      end
      cyc(1'b1, rb(), rb(), fetch_v(1'b1));
      n++;
      e = '0;
      e.sb = 2'b11;
      e.ext = 1'b1;
      e.ctr = 4'b0001;
      cyc(rb(), rb(), rb(), e);
      n++;
      if (op == 6'b000000 && r_legal(fn)) begin
         e = '0;
         e.sa = 1'b1;
         e.ctr = fn[3:0];
         cyc(rb(), rb(), ov, e);
         n++;
         if (ov && (fn == 6'b100000 || fn == 6'b100010)) do_trap(2'b01, n);
         else do_wb(1'b1, 1'b0, n);
      end else if (op == 6'b100011 || op == 6'b101011) begin
         e = '0;
         e.sa = 1'b1;
         e.sb = 2'b10;
         e.ext = 1'b1;
         e.ctr = 4'b0001;
         cyc(rb(), rb(), rb(), e);
         n++;
         e = '0;
         e.req = 1'b1;
         e.iord = 1'b1;
         e.rd = (op == 6'b100011);
         e.wr = (op == 6'b101011);
         for (int i = 0; i < mw; i++) begin
            cyc(1'b0, rb(), rb(), e);
            n++;
         end
         if (abort) begin
            reset_cyc();
            n++;
            return;
         end
         cyc(1'b1, rb(), rb(), e);
         n++;
         if (op == 6'b100011) do_wb(1'b0, 1'b1, n);
      end else if (op == 6'b000100 || op == 6'b000101) begin
         e = '0;
         e.sa = 1'b1;
         e.ctr = 4'b0011;
         e.pcs = 2'b01;
         e.pcw = (op == 6'b000100) ? z : ~z;
         cyc(rb(), z, rb(), e);
         n++;
      end else if (op == 6'b000010) begin
         e = '0;
         e.pcw = 1'b1;
         e.pcs = 2'b10;
         cyc(rb(), rb(), rb(), e);
         n++;
      end else if (op >= 6'b001000 && op <= 6'b001110) begin
         chk_ov = 1'b0;
         case (op)
            6'b001000: begin c = 4'b0000; ex = 1'b1; chk_ov = 1'b1; end
            6'b001001: begin c = 4'b0001; ex = 1'b1; end
            6'b001010: begin c = 4'b1010; ex = 1'b1; end
            6'b001011: begin c = 4'b1011; ex = 1'b1; end
            6'b001100: begin c = 4'b0100; ex = 1'b0; end
            6'b001101: begin c = 4'b0101; ex = 1'b0; end
            default:   begin c = 4'b0110; ex = 1'b0; end
         endcase
         e = '0;
         e.sa = 1'b1;
         e.sb = 2'b10;
         e.ext = ex;
         e.ctr = c;
         cyc(rb(), rb(), ov, e);
         n++;
         if (chk_ov && ov) do_trap(2'b01, n);
         else do_wb(1'b0, 1'b0, n);
      end else begin
         do_trap(2'b10, n);
      end
   endtask

   task automatic clr_seen();
      trap_seen = 0;
      rw_seen   = 0;
      irw_seen  = 0;
   endtask

   logic [5:0] ops[16] = '{6'b000000, 6'b000000, 6'b000000, 6'b100011,
                           6'b101011, 6'b000100, 6'b000101, 6'b000010,
                           6'b001000, 6'b001001, 6'b001010, 6'b001011,
                           6'b001100, 6'b001101, 6'b001110, 6'b001111};

   initial begin
      int n;
      logic [5:0] op;
      logic [5:0] fn;
      Reset  = 1'b1;
      Op     = '0;
      Funct  = '0;
      Zero   = 1'b0;
      Overfl = 1'b0;
      MemAck = 1'b0;
      #1;
      reset_cyc();
      reset_cyc();

      clr_seen();
      run_instr(6'b000000, 6'b101010, 1'b1, 1'b0, 3, 0, 0, n);
      check("slt_cycles", n, 7);
      check("slt_irwrite_pulses", irw_seen, 1);
      check("slt_regwrite", rw_seen, 1);

      clr_seen();
      run_instr(6'b000000, 6'b100000, 1'b1, 1'b0, 0, 0, 0, n);
      check("add_ovf_cycles", n, 4);
      check("add_ovf_trap", trap_seen, 1);
      check("add_ovf_regwrite", rw_seen, 0);
      check("add_ovf_cause", int'(TrapCause), 1);

      clr_seen();
      run_instr(6'b000000, 6'b100001, 1'b1, 1'b0, 0, 0, 0, n);
      check("addu_ovf_regwrite", rw_seen, 1);
      check("addu_ovf_trap", trap_seen, 0);

      run_instr(6'b100011, 6'b000000, 1'b0, 1'b0, 0, 2, 0, n);
      check("lw_wait2_cycles", n, 7);
      run_instr(6'b000100, 6'b000000, 1'b0, 1'b1, 0, 0, 0, n);
      check("beq_cycles", n, 3);
      run_instr(6'b000101, 6'b000000, 1'b0, 1'b1, 0, 0, 0, n);
      run_instr(6'b001101, 6'b000000, 1'b1, 1'b0, 0, 0, 0, n);
      check("ori_cycles", n, 4);

      run_instr(6'b111111, 6'b000000, 1'b0, 1'b0, 0, 0, 0, n);
      check("illegal_cycles", n, 3);
      check("illegal_cause", int'(TrapCause), 2);

      run_instr(6'b101011, 6'b000000, 1'b0, 1'b0, 0, 2, 1, n);
      check("sw_reset_cause", int'(TrapCause), 0);
      run_instr(6'b101011, 6'b000000, 1'b0, 1'b0, 0, 0, 0, n);
      check("sw_cycles", n, 4);

      for (int k = 0; k < 400; k++) begin
         op = ops[$urandom_range(15)];
         if ($urandom_range(7) == 0) op = 6'($urandom);
         fn = 6'($urandom);
         if ($urandom_range(3) != 0) fn = {3'b100, 3'($urandom)};
         run_instr(op, fn, rb(), rb(), $urandom_range(2),
                   $urandom_range(2), ($urandom_range(19) == 0), n);
      end

      chk = 1'b0;
      @(posedge Clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
